instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Upstream sequencer for the cpu block. Owns the program counter and reads 16-bit instructions from a synchronous instruction ROM.
- Presents each instruction to the cpu on its instruction bus, pulses the cpu's instruction-register load, then pulses the cpu start strobe.
- Waits for the cpu wait flag to drop and rise again before advancing PC. Replaces the hand-driven load/s/in stimulus used in lab benches.

Parameters:
- ADDR_W, 8, PC and ROM address width.
- DATA_W, 16, instruction width; must match the cpu instruction bus.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock shared with cpu.
- reset  input  1  synchronous, active-high; same net as cpu reset.
- run  input  1  level; 1 = fetch/execute continuously, 0 = stop at the next instruction boundary.
- w  input  1  cpu wait flag; 1 = cpu idle in its Wait state.
- mem_rdata  input  DATA_W  ROM read data, valid the cycle after mem_rd.
- mem_addr  output  ADDR_W  ROM address, equal to pc.
- mem_rd  output  1  ROM read strobe.
- instr  output  DATA_W  registered instruction; connects to cpu in.
- load  output  1  one-cycle pulse; connects to cpu load.
- s  output  1  one-cycle pulse; connects to cpu s.
- pc  output  ADDR_W  current program counter.
- halted  output  1  high once a HALT instruction has been fetched.
- busy  output  1  high in every state except IDLE and HALTED.

Behaviour:
- Reset (sync): state=IDLE, pc=RESET_PC, instr=0; load, s, mem_rd, halted and busy all 0. Reset in any state, including mid-handshake, takes effect at that edge; the cpu is reset on the same edge.
- States, one per clock:
  - IDLE: if run=1, go to FETCH.
  - FETCH: mem_rd=1, mem_addr=pc; go to CAPTURE.
  - CAPTURE: if mem_rdata[15:13]==3'b111 (HALT), go to HALTED; instr is not updated and load/s are not pulsed. Otherwise instr<=mem_rdata and go to LOAD.
  - LOAD: load=1 for exactly one cycle; the cpu IR captures instr at the end of this cycle. Go to START.
  - START: s=1 for exactly one cycle. Go to WAIT_LO.
  - WAIT_LO: stay until w==0 (cpu has left Wait), then go to WAIT_HI.
  - WAIT_HI: stay until w==1. Then pc<=pc+1, wrapping 2^ADDR_W-1 to 0. Go to FETCH if run=1, else IDLE.
  - HALTED: halted=1 and pc is frozen. Exit only by reset.
- Latency: 4 cycles from FETCH entry to the s pulse, plus cpu execution time.
- Exactly one load pulse and one s pulse per executed instruction. s and load are never asserted together.
- A run fall mid-instruction does not abort it; the current instruction completes.
- If w is already 0 when START is entered, WAIT_LO still takes one cycle.
- If w stays 1 forever (cpu stuck), the block waits forever. No timeout.
- pc changes only in WAIT_HI or on reset.

Optional Feature:
- SINGLE_STEP_EN defined: adds input step (1 bit).
  - IDLE advances to FETCH on run=1 OR a step rising edge. The edge detect uses a registered copy of step that is reset to 0.
  - With run=0, WAIT_HI always returns to IDLE, so one step edge executes exactly one instruction.
- SINGLE_STEP_EN undefined: no step port; behaviour as above.

Decomposition:
- Shared package/defines: state encodings (3-bit IDLE..HALTED), HALT_OPCODE=3'b111, and the opcode field position [15:13], shared with the cpu decoder.
- One sub-module, pc_counter: ADDR_W register with sync reset to RESET_PC, enable, and +1 wrap.

Test Plan:
- ROM[0]=16'hD105 (MOV R1,#5), ROM[1]=16'hE000; reset, run=1 -> one load and one s pulse, pc advances 0->1, then halted=1 with pc=1 and no further load/s; cpu R1=5.
- ROM holds MOV R0,#2; MOV R1,#3; ADD R2,R0,R1; HALT -> R2=5 and halted at pc=3; exactly 3 s pulses counted.
- Fill ROM with non-HALT MOVs, ADDR_W=2 -> pc sequence 0,1,2,3,0; wraps with no glitch.
- Drop run during WAIT_LO -> instruction completes, pc increments once, block sits in IDLE with busy=0; raising run resumes at the new pc.
- Assert reset during WAIT_HI -> next cycle state=IDLE, pc=RESET_PC, s=load=0; rerun executes from address 0.
- SINGLE_STEP_EN, run=0: two step pulses -> exactly two instructions executed, pc=2, busy=0 between steps.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: state encodings and HALT opcode decode shared by the fetch sequencer and cpu decoder.
package instr_fetch_pkg;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_LOAD    = 3'd3;
    localparam logic [2:0] S_START   = 3'd4;
    localparam logic [2:0] S_WAIT_LO = 3'd5;
    localparam logic [2:0] S_WAIT_HI = 3'd6;
    localparam logic [2:0] S_HALTED  = 3'd7;
    localparam logic [2:0] HALT_OPCODE = 3'b111;
    localparam int OP_HI = 15;
    localparam int OP_LO = 13;

    function automatic logic is_halt_op(input logic [15:0] i);
        return i[OP_HI:OP_LO] == HALT_OPCODE;
    endfunction
endpackage

// File: rtl/pc_counter.sv
// pc_counter: program counter with sync reset to RESET_PC and +1 wrap on enable.
module pc_counter #(
    parameter int unsigned ADDR_W = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic [ADDR_W-1:0] pc
);
    always_ff @(posedge clk)
        if (reset) pc <= RESET_PC;
        else if (en) pc <= pc + 1'b1;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetches instructions from a sync ROM and hands them to the cpu via load/s handshake.
// Optional SINGLE_STEP_EN adds a step input whose rising edge starts one instruction from IDLE.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
`ifdef SINGLE_STEP_EN
    input  logic              step,
`endif
    input  logic              w,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic [DATA_W-1:0] instr,
    output logic              load,
    output logic              s,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              busy
);
    logic [2:0] state;
    logic go;
`ifdef SINGLE_STEP_EN
    logic step_q;
    always_ff @(posedge clk) step_q <= reset ? 1'b0 : step;
    assign go = run | (step & ~step_q);
`else
    assign go = run;
`endif

    pc_counter #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
        .clk(clk),
        .reset(reset),
        .en(state == S_WAIT_HI && w),
        .pc(pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            instr <= '0;
        end else begin
            case (state)
                S_IDLE:    state <= go ? S_FETCH : S_IDLE;
                S_FETCH:   state <= S_CAPTURE;
                S_CAPTURE: begin
                    if (is_halt_op(mem_rdata[15:0])) state <= S_HALTED;
                    else begin
                        instr <= mem_rdata;
                        state <= S_LOAD;
                    end
                end
                S_LOAD:    state <= S_START;
                S_START:   state <= S_WAIT_LO;
                S_WAIT_LO: state <= w ? S_WAIT_LO : S_WAIT_HI;
                S_WAIT_HI: state <= !w ? S_WAIT_HI : run ? S_FETCH : S_IDLE;
                default:   state <= S_HALTED;
            endcase
        end
    end

    assign mem_addr = pc;
    assign mem_rd   = state == S_FETCH;
    assign load     = state == S_LOAD;
    assign s        = state == S_START;
    assign halted   = state == S_HALTED;
    assign busy     = state != S_IDLE && state != S_HALTED;
endmodule
